// File: rtl/stage_execute_pkg.sv
// Shared definitions for the MIPS Execute stage: default widths, ALU op codes
// and the muldiv FSM state encoding.
package stage_ex_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;
   localparam logic [3:0] ALU_MULT = 4'd12;
   localparam logic [3:0] ALU_DIV  = 4'd13;
   localparam logic [3:0] ALU_MFHI = 4'd14;
   localparam logic [3:0] ALU_MFLO = 4'd15;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   function automatic logic is_muldiv_op(input logic [3:0] op);
      return (op == ALU_MULT) || (op == ALU_DIV);
   endfunction

endpackage

// File: rtl/stage_execute_muldiv.sv
// Iterative signed multiply/divide unit owning HI/LO: one shift-add or
// restoring-subtract step per cycle on operand magnitudes, signs fixed at the end.
module muldiv_unit
   import stage_ex_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              op_div,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [0:0]          state;
   logic [CNT_W-1:0]    count;
   logic [DATA_W-1:0]   acc_hi;
   logic [DATA_W-1:0]   acc_lo;
   logic [DATA_W-1:0]   mag_b;
   logic                is_div;
   logic                neg_q;
   logic                neg_r;
   logic [DATA_W:0]     partial;
   logic [DATA_W-1:0]   step_hi;
   logic [DATA_W-1:0]   step_lo;
   logic [2*DATA_W-1:0] product;
   logic [DATA_W-1:0]   fin_hi;
   logic [DATA_W-1:0]   fin_lo;

   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
      return x[DATA_W-1] ? -x : x;
   endfunction

   assign busy = (state == ST_BUSY);
   assign done = busy && (count == '0);

   // acc_hi is the partial product / running remainder, acc_lo the multiplier / quotient
   always_comb begin
      partial = '0;
      step_hi = acc_hi;
      step_lo = acc_lo;
      if (is_div) begin
         partial = {acc_hi, acc_lo[DATA_W-1]};
         if (partial >= {1'b0, mag_b}) begin
            partial = partial - {1'b0, mag_b};
            step_lo = {acc_lo[DATA_W-2:0], 1'b1};
         end else begin
            step_lo = {acc_lo[DATA_W-2:0], 1'b0};
         end
         step_hi = partial[DATA_W-1:0];
      end else begin
         partial = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
         step_hi = partial[DATA_W:1];
         step_lo = {partial[0], acc_lo[DATA_W-1:1]};
      end
   end

   // A zero divisor naturally leaves |dividend| as remainder; only the quotient is forced
   always_comb begin
      product = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
      fin_hi  = product[2*DATA_W-1:DATA_W];
      fin_lo  = product[DATA_W-1:0];
      if (is_div) begin
         fin_lo = neg_q ? -step_lo : step_lo;
         fin_hi = neg_r ? -step_hi : step_hi;
         if (mag_b == '0) begin
            fin_lo = '1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         count  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         mag_b  <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc_hi <= '0;
                  acc_lo <= magnitude(a);
                  mag_b  <= magnitude(b);
                  is_div <= op_div;
                  neg_q  <= a[DATA_W-1] ^ b[DATA_W-1];
                  neg_r  <= a[DATA_W-1];
                  count  <= CNT_W'(DATA_W - 1);
                  state  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               if (count == '0) begin
                  hi    <= fin_hi;
                  lo    <= fin_lo;
                  state <= ST_IDLE;
               end else begin
                  count <= count - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/stage_execute.sv
// MIPS Execute stage: operand/destination muxes, ALU and the EX/MEM register.
// Define STAGE_EX_MULDIV_EN to build in MULT/DIV/MFHI/MFLO with HI/LO and the stall.
module stage_execute
   import stage_ex_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  i_reset,
   input  logic [DATA_W-1:0]     i_rs_reg,
   input  logic [DATA_W-1:0]     i_rt_reg,
   input  logic [DATA_W-1:0]     i_imm,
   input  logic [4:0]            i_shamt,
   input  logic [REG_ADDR_W-1:0] i_rt_addr,
   input  logic [REG_ADDR_W-1:0] i_rd_addr,
   input  logic [3:0]            is_alu_op,
   input  logic                  is_ALUSrc,
   input  logic                  is_RegDst,
   input  logic                  is_RegWrite,
   input  logic                  is_MemtoReg,
   input  logic                  is_MemWrite,
   input  logic                  is_MemRead,
   input  logic                  i_flush,
   output logic [DATA_W-1:0]     o_ALU_res,
   output logic [DATA_W-1:0]     o_rt_reg,
   output logic [REG_ADDR_W-1:0] o_addr_reg_dst,
   output logic                  os_zero,
   output logic                  os_RegWrite,
   output logic                  os_MemtoReg,
   output logic                  os_MemWrite,
   output logic                  os_MemRead,
   output logic                  o_stall
);

   logic [DATA_W-1:0]     op_a;
   logic [DATA_W-1:0]     op_b;
   logic [REG_ADDR_W-1:0] dst;
   logic [DATA_W-1:0]     alu_res;
   logic                  bubble;
   logic                  illegal_op;
   logic                  kill_ctl;
   logic                  kill_wr;

   assign op_a = i_rs_reg;
   assign op_b = is_ALUSrc ? i_imm : i_rt_reg;
   assign dst  = is_RegDst ? i_rd_addr : i_rt_addr;

`ifdef STAGE_EX_MULDIV_EN
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic              mdu_busy;
   logic              mdu_done;
   logic              mdu_start;

   assign mdu_start = is_muldiv_op(is_alu_op) && !mdu_busy;

   muldiv_unit #(
      .DATA_W(DATA_W)
   ) u_muldiv (
      .clk   (clk),
      .rst   (i_reset),
      .start (mdu_start),
      .op_div(is_alu_op == ALU_DIV),
      .a     (op_a),
      .b     (op_b),
      .busy  (mdu_busy),
      .done  (mdu_done),
      .hi    (hi),
      .lo    (lo)
   );

   // The final step cycle drops the stall so the next instruction arrives as HI/LO update
   assign o_stall    = mdu_start || (mdu_busy && !mdu_done);
   assign bubble     = mdu_start || mdu_busy;
   assign illegal_op = 1'b0;
`else
   assign o_stall    = 1'b0;
   assign bubble     = 1'b0;
   assign illegal_op = (is_alu_op[3:2] == 2'b11);
`endif

   always_comb begin
      alu_res = '0;
      case (is_alu_op)
         ALU_ADD:  alu_res = op_a + op_b;
         ALU_SUB:  alu_res = op_a - op_b;
         ALU_AND:  alu_res = op_a & op_b;
         ALU_OR:   alu_res = op_a | op_b;
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_NOR:  alu_res = ~(op_a | op_b);
         ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
         ALU_SLL:  alu_res = op_b << i_shamt;
         ALU_SRL:  alu_res = op_b >> i_shamt;
         ALU_SRA:  alu_res = $signed(op_b) >>> i_shamt;
         ALU_LUI:  alu_res = {op_b[15:0], {(DATA_W-16){1'b0}}};
`ifdef STAGE_EX_MULDIV_EN
         ALU_MFHI: alu_res = hi;
         ALU_MFLO: alu_res = lo;
`endif
         default:  alu_res = '0;
      endcase
   end

   // An illegal op still lets MemtoReg through; it has no architectural effect without a write
   assign kill_ctl = i_flush || bubble;
   assign kill_wr  = kill_ctl || illegal_op;

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         o_ALU_res      <= '0;
         o_rt_reg       <= '0;
         o_addr_reg_dst <= '0;
         os_zero        <= 1'b0;
         os_RegWrite    <= 1'b0;
         os_MemtoReg    <= 1'b0;
         os_MemWrite    <= 1'b0;
         os_MemRead     <= 1'b0;
      end else begin
         o_ALU_res      <= alu_res;
         o_rt_reg       <= i_rt_reg;
         o_addr_reg_dst <= dst;
         os_zero        <= (alu_res == '0);
         os_RegWrite    <= is_RegWrite && !kill_wr;
         os_MemtoReg    <= is_MemtoReg && !kill_ctl;
         os_MemWrite    <= is_MemWrite && !kill_wr;
         os_MemRead     <= is_MemRead && !kill_wr;
      end
   end

endmodule

// File: tb/tb_stage_execute.sv
// Self-checking bench for stage_execute: a behavioural model of the EX/MEM register
// and HI/LO, checked every cycle, plus hand-computed literal expectations.
module tb_stage_execute;
   import stage_ex_pkg::*;

   localparam int         DATA_W = 32;
   localparam logic [4:0] RT_IDX = 5'd7;
   localparam logic [4:0] RD_IDX = 5'd19;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [31:0] i_rs_reg;
   logic [31:0] i_rt_reg;
   logic [31:0] i_imm;
   logic [4:0]  i_shamt;
   logic [4:0]  i_rt_addr;
   logic [4:0]  i_rd_addr;
   logic [3:0]  is_alu_op;
   logic        is_ALUSrc;
   logic        is_RegDst;
   logic        is_RegWrite;
   logic        is_MemtoReg;
   logic        is_MemWrite;
   logic        is_MemRead;
   logic        i_flush;
   logic [31:0] o_ALU_res;
   logic [31:0] o_rt_reg;
   logic [4:0]  o_addr_reg_dst;
   logic        os_zero;
   logic        os_RegWrite;
   logic        os_MemtoReg;
   logic        os_MemWrite;
   logic        os_MemRead;
   logic        o_stall;

   stage_execute dut (
      .clk           (clk),
      .i_reset       (i_reset),
      .i_rs_reg      (i_rs_reg),
      .i_rt_reg      (i_rt_reg),
      .i_imm         (i_imm),
      .i_shamt       (i_shamt),
      .i_rt_addr     (i_rt_addr),
      .i_rd_addr     (i_rd_addr),
      .is_alu_op     (is_alu_op),
      .is_ALUSrc     (is_ALUSrc),
      .is_RegDst     (is_RegDst),
      .is_RegWrite   (is_RegWrite),
      .is_MemtoReg   (is_MemtoReg),
      .is_MemWrite   (is_MemWrite),
      .is_MemRead    (is_MemRead),
      .i_flush       (i_flush),
      .o_ALU_res     (o_ALU_res),
      .o_rt_reg      (o_rt_reg),
      .o_addr_reg_dst(o_addr_reg_dst),
      .os_zero       (os_zero),
      .os_RegWrite   (os_RegWrite),
      .os_MemtoReg   (os_MemtoReg),
      .os_MemWrite   (os_MemWrite),
      .os_MemRead    (os_MemRead),
      .o_stall       (o_stall)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: HI/LO and the EX/MEM contents expected after the latest edge
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] exp_res = '0;
   logic [31:0] exp_rt = '0;
   logic        exp_zero = 1'b0;
   logic [4:0]  exp_dst = '0;
   logic [3:0]  exp_ctl = '0;
   logic        chk_on = 1'b0;
   logic        chk_data = 1'b0;
   logic        chk_stall = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return ~(a | b);
         4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd7:  return (a < b) ? 32'd1 : 32'd0;
         4'd8:  return b << sh;
         4'd9:  return b >> sh;
         4'd10: return 32'($signed(b) >>> sh);
         4'd11: return b * 32'h0001_0000;
`ifdef STAGE_EX_MULDIV_EN
         4'd14: return m_hi;
         4'd15: return m_lo;
`endif
         default: return 32'd0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         checkOutput("os_ctl", {28'd0, os_RegWrite, os_MemtoReg, os_MemWrite, os_MemRead}, {28'd0, exp_ctl});
         if (chk_data) begin
            checkOutput("o_ALU_res", o_ALU_res, exp_res);
            checkOutput("os_zero", {31'd0, os_zero}, {31'd0, exp_zero});
            checkOutput("o_rt_reg", o_rt_reg, exp_rt);
            checkOutput("o_addr_reg_dst", {27'd0, o_addr_reg_dst}, {27'd0, exp_dst});
         end
         if (chk_stall) begin
            checkOutput("o_stall", {31'd0, o_stall}, 32'd0);
         end
      end
   end

   // ctl = {RegWrite, MemtoReg, MemWrite, MemRead}; returns just after the loading edge
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] imm, input logic [4:0] sh, input logic alusrc,
                                input logic regdst, input logic [3:0] ctl, input logic flush);
      logic [31:0] res;
      logic [3:0]  c;
      is_alu_op   = op;
      i_rs_reg    = rs;
      i_rt_reg    = rt;
      i_imm       = imm;
      i_shamt     = sh;
      is_ALUSrc   = alusrc;
      is_RegDst   = regdst;
      is_RegWrite = ctl[3];
      is_MemtoReg = ctl[2];
      is_MemWrite = ctl[1];
      is_MemRead  = ctl[0];
      i_flush     = flush;
      chk_stall   = 1'b1;
      res = model_alu(op, rs, alusrc ? imm : rt, sh);
      c   = ctl;
`ifndef STAGE_EX_MULDIV_EN
      if (op >= 4'd12) c = c & 4'b0100;
`endif
      if (flush) c = 4'b0000;
      @(posedge clk);
      #1;
      exp_res  = res;
      exp_zero = (res == 32'd0);
      exp_rt   = rt;
      exp_dst  = regdst ? RD_IDX : RT_IDX;
      exp_ctl  = c;
      chk_data = 1'b1;
   endtask

`ifdef STAGE_EX_MULDIV_EN
   task automatic runMulDiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int                 stall_cycles;
      logic signed [63:0] prod;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      stall_cycles = 0;
      is_alu_op   = op;
      i_rs_reg    = a;
      i_rt_reg    = b;
      is_ALUSrc   = 1'b0;
      is_RegWrite = 1'b1;
      is_MemtoReg = 1'b1;
      is_MemWrite = 1'b1;
      is_MemRead  = 1'b1;
      i_flush     = 1'b0;
      chk_stall   = 1'b0;
      #1;
      while (o_stall && stall_cycles < 100) begin
         @(posedge clk);
         #1;
         stall_cycles++;
         exp_ctl  = 4'b0000;
         chk_data = 1'b0;
      end
      checkOutput("stall_cycles", 32'(stall_cycles), 32'(DATA_W));
      @(posedge clk);
      #1;
      exp_ctl  = 4'b0000;
      chk_data = 1'b0;
      sa = a;
      sb = b;
      if (op == ALU_MULT) begin
         prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         m_hi = prod[63:32];
         m_lo = prod[31:0];
      end else if (b == 32'd0) begin
         m_lo = 32'hFFFF_FFFF;
         m_hi = a;
      end else begin
         m_lo = sa / sb;
         m_hi = sa % sb;
      end
   endtask
`endif

   initial begin
      i_reset     = 1'b1;
      i_rs_reg    = '0;
      i_rt_reg    = '0;
      i_imm       = '0;
      i_shamt     = '0;
      i_rt_addr   = RT_IDX;
      i_rd_addr   = RD_IDX;
      is_alu_op   = ALU_ADD;
      is_ALUSrc   = 1'b0;
      is_RegDst   = 1'b0;
      is_RegWrite = 1'b0;
      is_MemtoReg = 1'b0;
      is_MemWrite = 1'b0;
      is_MemRead  = 1'b0;
      i_flush     = 1'b0;
      chk_on      = 1'b1;
      chk_data    = 1'b1;
      chk_stall   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_res", o_ALU_res, 32'd0);
      i_reset = 1'b0;

      applyStimulus(ALU_ADD, 32'd5, 32'd0, 32'hFFFF_FFFB, 5'd0, 1'b1, 1'b1, 4'b1000, 1'b0);
      checkOutput("add_res_lit", o_ALU_res, 32'd0);
      checkOutput("add_zero_lit", {31'd0, os_zero}, 32'd1);
      checkOutput("add_regwrite_lit", {31'd0, os_RegWrite}, 32'd1);
      applyStimulus(ALU_SUB, 32'd10, 32'd3, 32'd0, 5'd0, 1'b0, 1'b0, 4'b1000, 1'b0);
      applyStimulus(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      applyStimulus(ALU_OR,  32'hF000_0000, 32'd0, 32'h0000_00AA, 5'd0, 1'b1, 1'b0, 4'b1000, 1'b0);
      applyStimulus(ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 5'd0, 1'b0, 1'b1, 4'b0101, 1'b0);
      applyStimulus(ALU_NOR, 32'h1234_0000, 32'h0000_5678, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      checkOutput("slt_lit", o_ALU_res, 32'd1);
      applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      checkOutput("sltu_lit", o_ALU_res, 32'd0);
      applyStimulus(ALU_SLL, 32'd0, 32'h0000_0081, 32'd0, 5'd3, 1'b0, 1'b1, 4'b1000, 1'b0);
      applyStimulus(ALU_SRL, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 1'b0, 1'b1, 4'b1000, 1'b0);
      applyStimulus(ALU_SRA, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 1'b0, 1'b1, 4'b1000, 1'b0);
      checkOutput("sra_lit", o_ALU_res, 32'hF800_0000);
      applyStimulus(ALU_LUI, 32'd0, 32'd0, 32'h0000_1234, 5'd0, 1'b1, 1'b0, 4'b1000, 1'b0);
      checkOutput("lui_lit", o_ALU_res, 32'h1234_0000);
      applyStimulus(ALU_ADD, 32'h0000_0100, 32'hDEAD_BEEF, 32'd8, 5'd0, 1'b1, 1'b0, 4'b0010, 1'b1);
      checkOutput("flush_memwrite_lit", {31'd0, os_MemWrite}, 32'd0);
      checkOutput("flush_res_lit", o_ALU_res, 32'h0000_0108);
      applyStimulus(ALU_ADD, 32'h0000_0100, 32'hDEAD_BEEF, 32'd8, 5'd0, 1'b1, 1'b0, 4'b0010, 1'b0);

`ifdef STAGE_EX_MULDIV_EN
      runMulDiv(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
      applyStimulus(ALU_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      checkOutput("mult_lo_lit", o_ALU_res, 32'hFFFF_FFEB);
      applyStimulus(ALU_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      checkOutput("mult_hi_lit", o_ALU_res, 32'hFFFF_FFFF);
      runMulDiv(ALU_DIV, 32'd7, 32'hFFFF_FFFE);
      applyStimulus(ALU_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      checkOutput("div_lo_lit", o_ALU_res, 32'hFFFF_FFFD);
      applyStimulus(ALU_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      checkOutput("div_hi_lit", o_ALU_res, 32'd1);
      runMulDiv(ALU_DIV, 32'd5, 32'd0);
      applyStimulus(ALU_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      checkOutput("div0_lo_lit", o_ALU_res, 32'hFFFF_FFFF);
      applyStimulus(ALU_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      checkOutput("div0_hi_lit", o_ALU_res, 32'd5);
      applyStimulus(ALU_ADD, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      runMulDiv(ALU_MULT, 32'h1234_5678, 32'hFFFF_FF00);
      applyStimulus(ALU_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      applyStimulus(ALU_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      runMulDiv(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
      applyStimulus(ALU_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      applyStimulus(ALU_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);

      // Abort a MULT part-way through with reset
      is_alu_op   = ALU_MULT;
      i_rs_reg    = 32'd1234;
      i_rt_reg    = 32'd5678;
      is_ALUSrc   = 1'b0;
      is_RegWrite = 1'b1;
      is_MemtoReg = 1'b1;
      is_MemWrite = 1'b1;
      is_MemRead  = 1'b1;
      chk_stall   = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         exp_ctl  = 4'b0000;
         chk_data = 1'b0;
      end
      checkOutput("stall_mid_op", {31'd0, o_stall}, 32'd1);
      i_reset     = 1'b1;
      is_alu_op   = ALU_ADD;
      i_rs_reg    = '0;
      i_rt_reg    = '0;
      is_RegWrite = 1'b0;
      is_MemtoReg = 1'b0;
      is_MemWrite = 1'b0;
      is_MemRead  = 1'b0;
      exp_res     = '0;
      exp_rt      = '0;
      exp_zero    = 1'b0;
      exp_dst     = '0;
      exp_ctl     = '0;
      chk_data    = 1'b1;
      chk_stall   = 1'b1;
      #1;
      checkOutput("abort_stall_lit", {31'd0, o_stall}, 32'd0);
      checkOutput("abort_rt_lit", o_rt_reg, 32'd0);
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      m_hi    = '0;
      m_lo    = '0;
      applyStimulus(ALU_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
      checkOutput("abort_mfhi_lit", o_ALU_res, 32'd0);
`else
      applyStimulus(ALU_MULT, 32'd7, 32'd3, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1111, 1'b0);
      checkOutput("illegal_res_lit", o_ALU_res, 32'd0);
      checkOutput("illegal_regwrite_lit", {31'd0, os_RegWrite}, 32'd0);
      checkOutput("illegal_memtoreg_lit", {31'd0, os_MemtoReg}, 32'd1);
      applyStimulus(ALU_DIV, 32'd9, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 4'b1111, 1'b0);
      applyStimulus(ALU_MFHI, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1111, 1'b0);
      applyStimulus(ALU_MFLO, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b1, 4'b0011, 1'b0);
      applyStimulus(ALU_ADD, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b1, 4'b1111, 1'b0);
`endif

      @(negedge clk);
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
